// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, Funct3 codes and access size.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SizeB = 2'd0,
        SizeH = 2'd1,
        SizeW = 2'd2
    } lsu_size_t;

    // Unlisted Funct3 codes fall back to a full-word access.
    function automatic lsu_size_t f3_size(logic [2:0] f3);
        lsu_size_t size;
        case (f3)
            F3_B, F3_BU: size = SizeB;
            F3_H, F3_HU: size = SizeH;
            F3_W:        size = SizeW;
            default:     size = SizeW;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Req/ack data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBe;
    logic        MemAck;
    logic [31:0] MemRData;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData, MemBe,
        input  MemAck, MemRData
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData, MemBe,
        output MemAck, MemRData
    );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it to 32 bits.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result_o = {24'h0, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result_o = {16'h0, half_sel};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory front end: alignment check, store lane steering and a req/ack bus FSM that stalls
// the core until completion. Optional ack watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              MisalignedErr,
    output logic              BusErr,
    load_store_unit_if.master bus
);

    lsu_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] word_q, word_d;
    logic [31:0] read_data_q, read_data_d;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;
`endif

    lsu_size_t   size;
    logic        access;
    logic        misaligned;
    logic        start;
    logic [3:0]  lane_be;
    logic [31:0] lane_data;
    logic [31:0] ext_data;

    load_extend u_load_extend (
        .word_i   (word_q),
        .offset_i (offset_q),
        .funct3_i (f3_q),
        .result_o (ext_data)
    );

    always_comb begin
        size   = f3_size(Funct3);
        access = MemRead | MemWrite;
        case (size)
            SizeB:   misaligned = 1'b0;
            SizeH:   misaligned = ALUResult[0];
            default: misaligned = |ALUResult[1:0];
        endcase
    end

    // Stores replicate the datum across the word so the byte enables pick the live lane.
    always_comb begin
        lane_be   = 4'b1111;
        lane_data = WriteData;
        case (size)
            SizeB: begin
                lane_be   = 4'b0001 << ALUResult[1:0];
                lane_data = {4{WriteData[7:0]}};
            end
            SizeH: begin
                lane_be   = 4'b0011 << {ALUResult[1], 1'b0};
                lane_data = {2{WriteData[15:0]}};
            end
            default: ;
        endcase
        if (!MemWrite) begin
            lane_be   = 4'b0000;
            lane_data = 32'h0;
        end
    end

    assign start         = (state_q == StIdle) & access & ~misaligned;
    assign Stall         = start | (state_q == StReq);
    assign MisalignedErr = (state_q == StIdle) & access & misaligned;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        f3_d        = f3_q;
        offset_d    = offset_q;
        word_d      = word_q;
        read_data_d = read_data_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    req_d    = 1'b1;
                    we_d     = MemWrite;
                    addr_d   = {ALUResult[31:2], 2'b00};
                    wdata_d  = lane_data;
                    be_d     = lane_be;
                    f3_d     = Funct3;
                    offset_d = ALUResult[1:0];
                    state_d  = StReq;
`ifdef LSU_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            StReq: begin
                if (bus.MemAck) begin
                    if (!we_q) begin
                        word_d = bus.MemRData;
                    end
                    req_d   = 1'b0;
                    state_d = StDone;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: zero the captured word so DONE also writes back 0.
                    req_d       = 1'b0;
                    bus_err_d   = 1'b1;
                    word_d      = 32'h0;
                    read_data_d = 32'h0;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StDone: begin
                if (!we_q) begin
                    read_data_d = ext_data;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            f3_q        <= 3'h0;
            offset_q    <= 2'h0;
            word_q      <= 32'h0;
            read_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            f3_q        <= f3_d;
            offset_q    <= offset_d;
            word_q      <= word_d;
            read_data_q <= read_data_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign BusErr = bus_err_q;
`else
    assign BusErr = 1'b0;
`endif

    assign ReadData     = read_data_q;
    assign bus.MemReq   = req_q;
    assign bus.MemWe    = we_q;
    assign bus.MemAddr  = addr_q;
    assign bus.MemWData = wdata_q;
    assign bus.MemBe    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-level reference model.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int LongReq = 4;
`else
    localparam int LongReq = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Stall, MisalignedErr, BusErr;

    int num_checks = 0;
    int num_errors = 0;
    logic [31:0] exp_rd = 32'h0;

    load_store_unit_if bus ();

    load_store_unit #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .Funct3        (Funct3),
        .ALUResult     (ALUResult),
        .WriteData     (WriteData),
        .ReadData      (ReadData),
        .Stall         (Stall),
        .MisalignedErr (MisalignedErr),
        .BusErr        (BusErr),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
        int     sz  = size_of(f3);
        int     off = int'(a % 4);
        longint v;
        v = (longint'(w) >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_be(logic [2:0] f3, logic [31:0] a);
        int sz  = size_of(f3);
        int off = int'(a % 4);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] wd);
        int sz = size_of(f3);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % sz) +: 8];
        return w;
    endfunction

    // Entered #1 after a rising edge with the DUT idle; returns at the same phase.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] word, input int req_cycles);
        bit mis;
        int stall_cnt = 0;
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        ALUResult = a;
        WriteData = wd;
        mis = (rd | wr) && ((a % size_of(f3)) != 0);
        @(negedge clk);
        check("misaligned_err", MisalignedErr, mis);
        if (mis) begin
            check("stall_misaligned", Stall, 0);
            @(posedge clk); #1;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            check("req_misaligned", bus.MemReq, 0);
            check("rdata_misaligned", ReadData, exp_rd);
            return;
        end
        if (Stall) stall_cnt++;
        @(posedge clk); #1;
        for (int c = 0; c < req_cycles; c++) begin
            bus.MemAck   = (c == req_cycles - 1);
            bus.MemRData = (c == req_cycles - 1) ? word : $urandom;
            @(negedge clk);
            check("mem_req", bus.MemReq, 1);
            if (c == 0) begin
                check("mem_we", bus.MemWe, wr);
                check("mem_addr", bus.MemAddr, a & 32'hFFFF_FFFC);
                check("mem_be", bus.MemBe, wr ? model_be(f3, a) : 4'b0000);
                if (wr) check("mem_wdata", bus.MemWData, model_wdata(f3, wd));
            end
            if (Stall) stall_cnt++;
            @(posedge clk); #1;
        end
        bus.MemAck = 1'b0;
        @(negedge clk);
        check("stall_done", Stall, 0);
        check("req_done", bus.MemReq, 0);
        check("bus_err_done", BusErr, 0);
        @(posedge clk); #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (!wr) exp_rd = model_load(f3, a, word);
        check("stall_len", stall_cnt, req_cycles + 1);
        check("read_data", ReadData, exp_rd);
        @(negedge clk);
        check("no_reissue", bus.MemReq, 0);
        @(posedge clk); #1;
    endtask

    logic [2:0] load_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    initial begin
        rst          = 1'b1;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Funct3       = 3'd0;
        ALUResult    = 32'h0;
        WriteData    = 32'h0;
        bus.MemAck   = 1'b0;
        bus.MemRData = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read_data", ReadData, 0);
        check("rst_req", bus.MemReq, 0);
        check("rst_we", bus.MemWe, 0);
        check("rst_addr", bus.MemAddr, 0);
        check("rst_wdata", bus.MemWData, 0);
        check("rst_be", bus.MemBe, 0);
        check("rst_bus_err", BusErr, 0);
        check("rst_stall", Stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_access(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 1);
        check("lw_value", ReadData, 32'hDEAD_BEEF);
        do_access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 1);
        check("lb_value", ReadData, 32'hFFFF_FF80);
        do_access(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 1);
        check("lbu_value", ReadData, 32'h0000_0080);
        do_access(0, 1, 3'd1, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 1);
        check("sh_keeps_rdata", ReadData, 32'h0000_0080);
        do_access(1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 1);
        do_access(1, 0, 3'd2, 32'h300, 32'h0, 32'h0BAD_F00D, LongReq);

`ifdef LSU_TIMEOUT_EN
        MemRead   = 1'b1;
        Funct3    = 3'd2;
        ALUResult = 32'h80;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("to_stall", Stall, 1);
            check("to_bus_err_low", BusErr, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to_bus_err", BusErr, 1);
        check("to_stall_done", Stall, 0);
        check("to_req_drop", bus.MemReq, 0);
        @(posedge clk); #1;
        MemRead = 1'b0;
        exp_rd  = 32'h0;
        @(negedge clk);
        check("to_bus_err_pulse", BusErr, 0);
        check("to_read_data", ReadData, exp_rd);
        @(posedge clk); #1;
`endif

        // Reset while a second access is waiting for its ack.
        MemRead   = 1'b1;
        Funct3    = 3'd2;
        ALUResult = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        MemRead = 1'b0;
        exp_rd  = 32'h0;
        @(negedge clk);
        check("rst_mid_req", bus.MemReq, 0);
        check("rst_mid_stall", Stall, 0);
        check("rst_mid_rdata", ReadData, exp_rd);
        @(posedge clk); #1;

        for (int n = 0; n < 60; n++) begin
            int          kind = int'($urandom_range(0, 9));
            bit          rd   = (kind <= 5) || (kind == 9);
            bit          wr   = (kind >= 6);
            logic [2:0]  f3   = wr ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 7)];
            logic [31:0] a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(f3)) - 32'd1);
            do_access(rd, wr, f3, a, $urandom, $urandom, int'($urandom_range(1, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end

endmodule
